// File: rtl/regfile_wr_arbiter_if.sv
// ============================================================================
// Module : regfile_wr_arbiter_if
// Brief  : Requester-side and register-file-side signals of the write arbiter
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface regfile_wr_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic              wr0_valid;
  logic [ADDR_W-1:0] wr0_addr;
  logic [DATA_W-1:0] wr0_data;
  logic              wr0_ready;
  logic              wr1_valid;
  logic [ADDR_W-1:0] wr1_addr;
  logic [DATA_W-1:0] wr1_data;
  logic              wr1_ready;
  logic              rf_writeen;
  logic [ADDR_W-1:0] rf_writeaddr;
  logic [DATA_W-1:0] rf_writedata;
  logic              busy;
  logic              grant_id;
  logic [7:0]        drop_cnt;

  modport slave (
    input  wr0_valid, wr0_addr, wr0_data,
    input  wr1_valid, wr1_addr, wr1_data,
    output wr0_ready, wr1_ready,
    output rf_writeen, rf_writeaddr, rf_writedata,
    output busy, grant_id, drop_cnt
  );

  modport master (
    output wr0_valid, wr0_addr, wr0_data,
    output wr1_valid, wr1_addr, wr1_data,
    input  wr0_ready, wr1_ready,
    input  rf_writeen, rf_writeaddr, rf_writedata,
    input  busy, grant_id, drop_cnt
  );
endinterface

`default_nettype wire

// File: rtl/regfile_wr_arbiter.sv
// ============================================================================
// Module : regfile_wr_arbiter
// Brief  : Round-robin owner of the register-file write port (two requesters).
//          Define REGFILE_CLEAR_EN for the post-reset r1..r15 zero sweep.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module regfile_wr_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  regfile_wr_arbiter_if.slave bus
);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

`ifdef REGFILE_CLEAR_EN
  localparam int     NUM_REGS  = 2 ** ADDR_W;
  localparam state_t RST_STATE = ST_CLEAR;
`else
  localparam state_t RST_STATE = ST_RUN;
`endif

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0] rf_data_q, rf_data_d;
  logic              grant_id_q, grant_id_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;
  logic              wr0_ready, wr1_ready;
  logic [ADDR_W-1:0] take_addr;
  logic [DATA_W-1:0] take_data;

`ifdef REGFILE_CLEAR_EN
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              busy_q, busy_d;

  // Sweep counter restarts at r1 on every reset, including one taken mid-sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_addr_q <= ADDR_W'(1);
      busy_q     <= 1'b0;
    end else begin
      clr_addr_q <= clr_addr_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.busy = busy_q;
`else
  assign bus.busy = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RST_STATE;
      last_grant_q <= 1'b1;
      rf_we_q      <= 1'b0;
      rf_addr_q    <= '0;
      rf_data_q    <= '0;
      grant_id_q   <= 1'b0;
      drop_cnt_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rf_we_q      <= rf_we_d;
      rf_addr_q    <= rf_addr_d;
      rf_data_q    <= rf_data_d;
      grant_id_q   <= grant_id_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    rf_we_d      = 1'b0;
    rf_addr_d    = rf_addr_q;
    rf_data_d    = rf_data_q;
    grant_id_d   = grant_id_q;
    drop_cnt_d   = drop_cnt_q;
    wr0_ready    = 1'b0;
    wr1_ready    = 1'b0;
    take_addr    = '0;
    take_data    = '0;
`ifdef REGFILE_CLEAR_EN
    clr_addr_d   = clr_addr_q;
    busy_d       = 1'b0;
`endif
    case (state_q)
      ST_CLEAR: begin
`ifdef REGFILE_CLEAR_EN
        rf_we_d    = 1'b1;
        rf_addr_d  = clr_addr_q;
        rf_data_d  = '0;
        busy_d     = 1'b1;
        clr_addr_d = clr_addr_q + ADDR_W'(1);
        if (clr_addr_q == ADDR_W'(NUM_REGS - 1)) begin
          state_d = ST_RUN;
        end
`else
        state_d = ST_RUN;
`endif
      end
      ST_RUN: begin
        // Under contention the port that did not win last time is served.
        wr0_ready = bus.wr0_valid & (~bus.wr1_valid | last_grant_q);
        wr1_ready = bus.wr1_valid & (~bus.wr0_valid | ~last_grant_q);
        if (wr0_ready || wr1_ready) begin
          take_addr    = wr1_ready ? bus.wr1_addr : bus.wr0_addr;
          take_data    = wr1_ready ? bus.wr1_data : bus.wr0_data;
          last_grant_d = wr1_ready;
          if (take_addr == '0) begin
            if (drop_cnt_q != 8'hFF) begin
              drop_cnt_d = drop_cnt_q + 8'd1;
            end
          end else begin
            rf_we_d    = 1'b1;
            rf_addr_d  = take_addr;
            rf_data_d  = take_data;
            grant_id_d = wr1_ready;
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign bus.wr0_ready    = wr0_ready;
  assign bus.wr1_ready    = wr1_ready;
  assign bus.rf_writeen   = rf_we_q;
  assign bus.rf_writeaddr = rf_addr_q;
  assign bus.rf_writedata = rf_data_q;
  assign bus.grant_id     = grant_id_q;
  assign bus.drop_cnt     = drop_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_wr_arbiter.sv
// ============================================================================
// Module : tb_regfile_wr_arbiter
// Brief  : Directed plus randomized checks of regfile_wr_arbiter against a model
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_wr_arbiter;

  logic clk;
  logic rst_n;

  regfile_wr_arbiter_if #(.DATA_W(16), .ADDR_W(4)) bus ();

  regfile_wr_arbiter #(.DATA_W(16), .ADDR_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_fail = 0;
  // Reference model state: who won last, what the write port shows next cycle.
  int          m_last;
  int          m_win;
  bit          m_we;
  logic [3:0]  m_addr;
  logic [15:0] m_data;
  int          m_gid;
  int          m_drop;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v0, input logic [3:0] a0, input logic [15:0] d0,
                       input bit v1, input logic [3:0] a1, input logic [15:0] d1);
    bus.wr0_valid = v0; bus.wr0_addr = a0; bus.wr0_data = d0;
    bus.wr1_valid = v1; bus.wr1_addr = a1; bus.wr1_data = d1;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(input bit v0, input logic [3:0] a0, input logic [15:0] d0,
                       input bit v1, input logic [3:0] a1, input logic [15:0] d1);
    logic [3:0]  a;
    logic [15:0] d;
    check("rf_writeen", bus.rf_writeen, m_we);
    if (m_we) begin
      check("rf_writeaddr", bus.rf_writeaddr, m_addr);
      check("rf_writedata", bus.rf_writedata, m_data);
      check("grant_id", bus.grant_id, m_gid);
    end
    check("drop_cnt", bus.drop_cnt, m_drop);
    check("busy_run", bus.busy, 0);
    drive(v0, a0, d0, v1, a1, d1);
    #1;
    if (v0 && v1)  m_win = 1 - m_last;
    else if (v0)   m_win = 0;
    else if (v1)   m_win = 1;
    else           m_win = -1;
    check("wr0_ready", bus.wr0_ready, m_win == 0);
    check("wr1_ready", bus.wr1_ready, m_win == 1);
    m_we = 1'b0;
    if (m_win >= 0) begin
      m_last = m_win;
      a = (m_win == 1) ? a1 : a0;
      d = (m_win == 1) ? d1 : d0;
      if (a == 4'd0) begin
        if (m_drop < 255) m_drop++;
      end else begin
        m_we = 1'b1; m_addr = a; m_data = d; m_gid = m_win;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 4'd0, 16'd0, 0, 4'd0, 16'd0);
    #1;
    check("rst_writeen", bus.rf_writeen, 0);
    check("rst_writeaddr", bus.rf_writeaddr, 0);
    check("rst_writedata", bus.rf_writedata, 0);
    check("rst_grant_id", bus.grant_id, 0);
    check("rst_drop_cnt", bus.drop_cnt, 0);
    check("rst_busy", bus.busy, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    m_last = 1; m_we = 1'b0; m_drop = 0; m_win = -1;
`ifdef REGFILE_CLEAR_EN
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      check("clr_writeen", bus.rf_writeen, 1);
      check("clr_writeaddr", bus.rf_writeaddr, k);
      check("clr_writedata", bus.rf_writedata, 0);
      check("clr_busy", bus.busy, 1);
    end
    @(negedge clk);
    check("clr_end_writeen", bus.rf_writeen, 0);
    check("clr_end_busy", bus.busy, 0);
`endif
  endtask

  initial begin
    bit          p0v, p1v;
    logic [3:0]  p0a, p1a;
    logic [15:0] p0d, p1d;

    do_reset();

    // First cycle after reset (or after the sweep): port 0 to r9.
    cycle(1, 4'd9, 16'h0042, 0, 4'd0, 16'd0);
    cycle(0, 4'd0, 16'd0, 0, 4'd0, 16'd0);
    cycle(1, 4'd3, 16'hBEEF, 0, 4'd0, 16'd0);
    cycle(0, 4'd1, 16'h1234, 1, 4'd4, 16'h1234);

    // Held contention must alternate 0,1,0,1.
    for (int i = 0; i < 4; i++) cycle(1, 4'd2, 16'h1111, 1, 4'd5, 16'h2222);
    cycle(0, 4'd0, 16'd0, 0, 4'd0, 16'd0);

    // Writes to r0 are accepted and counted, counter saturates.
    for (int i = 0; i < 260; i++) cycle(0, 4'd0, 16'd0, 1, 4'd0, 16'hFFFF);
    cycle(0, 4'd0, 16'd0, 0, 4'd0, 16'd0);

    p0v = 0; p1v = 0; p0a = '0; p1a = '0; p0d = '0; p1d = '0;
    for (int i = 0; i < 300; i++) begin
      if (i == 150) begin
        do_reset();
        p0v = 0; p1v = 0;
      end
      if (p0v && m_win != 0) p0v = ($urandom_range(7) != 0);
      else begin
        p0v = 1'($urandom_range(1));
        p0a = ($urandom_range(3) == 0) ? 4'd0 : 4'($urandom_range(15));
        p0d = 16'($urandom);
      end
      if (p1v && m_win != 1) p1v = ($urandom_range(7) != 0);
      else begin
        p1v = 1'($urandom_range(1));
        p1a = ($urandom_range(3) == 0) ? 4'd0 : 4'($urandom_range(15));
        p1d = 16'($urandom);
      end
      cycle(p0v, p0a, p0d, p1v, p1a, p1d);
    end
    cycle(0, 4'd0, 16'd0, 0, 4'd0, 16'd0);

`ifdef REGFILE_CLEAR_EN
    // Reset taken while the sweep is at r7 aborts it immediately.
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) @(negedge clk);
    check("mid_clr_addr", bus.rf_writeaddr, 7);
    rst_n = 1'b0;
    #1;
    check("mid_clr_writeen", bus.rf_writeen, 0);
    check("mid_clr_busy", bus.busy, 0);
    @(negedge clk);
    do_reset();
    cycle(1, 4'd6, 16'h0abc, 0, 4'd0, 16'd0);
    cycle(0, 4'd0, 16'd0, 0, 4'd0, 16'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
